trap_ctrl: RTL and testbench
============================

# trap_ctrl

Parametrised, fully synchronous successor to the Nabu CPLD trap/mode controller. Arbitrates NUM_SRC trap sources (IRQ, I/O violation, and future causes) and drives NMI to the Z80. Tracks trap state across M1 cycles, records which source caused each trap, and strobes the address-capture latch. Sits between the bus decode (violation/IRQ sources, M1 decode of new_isr/last_isr_jmp) and the Z80 NMI pin.

## Interface
Parameters:
- NUM_SRC, 4: number of trap sources; source 0 has highest priority.
- STICKY_MASK, 4'b1110: bit i = 1 makes source i sticky (edge-latched); 0 makes it level (resampled).
- SYNC_STAGES, 2: synchroniser depth for m1_n and src_req; minimum 2.

Ports:
- clk  in  1  system clock; one clock for the whole block.
- rst_n  in  1  reset, synchronous, active-low.
- m1_n  in  1  Z80 M1, asynchronous; synchronised internally.
- src_req  in  NUM_SRC  trap requests, active-high, asynchronous.
- src_en  in  NUM_SRC  per-source enable; disabled sources never become pending.
- ack_valid  in  1  one-clock pulse: clear sticky pending bit ack_idx.
- ack_idx  in  CAUSE_W  source index to clear; CAUSE_W = max(1, clog2(NUM_SRC)).
- new_isr  in  1  current M1 fetch is a trap-vector entry point.
- last_isr_jmp  in  1  current M1 fetch is the trap-exit jump.
- virtual_enabled  in  1  virtualisation active.
- trap_state  out  1  CPU is in trap mode; reset 1.
- nmi_n  out  1  NMI to CPU, active-low, registered; reset 1.
- capture_address  out  1  address capture enable; reset 0.
- pending  out  NUM_SRC  current pending vector; reset 0.
- cause  out  CAUSE_W  index of the source that opened the current trap; reset 0.
- cause_valid  out  1  cause is meaningful; reset 0.

## Operation
- m1_n passes through SYNC_STAGES flops, then one edge register, giving single-clock m1_fall and m1_rise pulses.
- Level source i: pending[i] <= src_req_s[i] & src_en[i] on m1_rise only.
- Sticky source i: set on a synchronised src_req rising edge when trap_state = 0 and src_en[i] = 1. Cleared by an ack_valid with ack_idx = i. Also cleared by a src_req rising edge while trap_state = 1. If set and clear coincide, clear wins.
- pending_any = |pending. Winner = lowest set index.
- Trap FSM has two states, RUN (trap_state = 0) and TRAP (trap_state = 1). Reset state is TRAP.
  - RUN -> TRAP on m1_fall with !virtual_enabled. No capture; cause_valid unchanged.
  - RUN -> TRAP on m1_fall with pending_any & new_isr. capture_address <= 1, cause <= winner, cause_valid <= 1.
  - TRAP -> RUN on m1_fall with last_isr_jmp & virtual_enabled. cause_valid <= 0.
- capture_address clears on the next m1_fall, so it is high for exactly one M1 cycle.
- nmi_n <= !(pending_any & !trap_state), registered.
- ack_idx values >= NUM_SRC are ignored.

## Timing
- An M1 edge is visible SYNC_STAGES+1 clocks after the pin changes. State updates occur on the following clock edge.
- NMI assertion latency: 1 clock after pending_any goes high in RUN.
- NMI deassertion latency: 1 clock after trap entry.
- Entry to and exit from TRAP happen only on m1_fall, never between M1 cycles.
- Simultaneous m1_fall and m1_rise cannot occur, because the synchronised signal changes at most once per clock.
- rst_n low mid-trap forces the reset values on the next clock. Synchroniser flops reset to m1_n = 1 and src_req = 0, so no spurious edge appears after reset.

## Configuration
- TRAP_CTRL_STATS_EN defined: adds output trap_count (8 bits, reset 0).
  - Increments on every RUN -> TRAP transition caused by pending_any & new_isr.
  - Saturates at 255; cleared only by reset.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- trap_pkg holds:
  - the trap_state_e enum (RUN, TRAP);
  - the default source index constants SRC_IRQ = 0, SRC_IO_VIOL = 1;
  - a cause-width function.
- Sub-module m1_edge_sync: parametrised synchroniser plus rise/fall pulse generator. Instantiated once for m1_n and once (NUM_SRC wide) for src_req.

## Test plan
- Reset: hold rst_n low 3 clocks -> trap_state = 1, nmi_n = 1, capture_address = 0, pending = 0, cause_valid = 0.
- Exit and IRQ entry:
  - virtual_enabled = 1, M1 cycle with last_isr_jmp = 1 -> trap_state = 0.
  - Raise src_req[0] -> pending[0] = 1 after the next m1_rise; nmi_n = 0 one clock later.
  - M1 with new_isr = 1 -> trap_state = 1, cause = 0, capture_address high for one M1 cycle, nmi_n = 1.
- Priority: src_req = 4'b1010 in RUN -> entry with cause = 1. Ack idx 1 -> pending = 4'b1000, nmi_n stays 1 while in TRAP.
- Sticky in trap: pulse src_req[2] while trap_state = 1 -> pending[2] stays 0. Ack and set on the same clock -> bit ends 0.
- Virtualisation off: virtual_enabled = 0, last_isr_jmp = 1 -> trap_state remains 1, and no capture on any M1.
- With TRAP_CTRL_STATS_EN: 300 IRQ entry/exit cycles -> trap_count = 255.

Source files
------------

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and helpers for the trap controller
// Purpose: trap FSM state enum, default trap source indices, cause width helper.
// Ports: none (package).
package trap_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } trap_state_e;

  localparam int SRC_IRQ     = 0;
  localparam int SRC_IO_VIOL = 1;

  // Width of a source index; never below 1 so a single-source build still has a port.
  function automatic int cause_width(input int num_src);
    return (num_src <= 2) ? 1 : $clog2(num_src);
  endfunction

endpackage

// File: rtl/trap_ctrl_m1_edge_sync.sv
// rtl/trap_ctrl_m1_edge_sync.sv - multi-flop synchroniser with registered edge pulses
// Purpose: brings W asynchronous bits into the clk domain and produces one-clock
//          rise/fall pulses per bit.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   din   [W]    asynchronous input
//   level [W]    synchronised level
//   rise  [W]    one-clock pulse after a synchronised 0->1 transition
//   fall  [W]    one-clock pulse after a synchronised 1->0 transition
module m1_edge_sync #(
  parameter int           W       = 1,
  parameter int           STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]             edge_q;

  assign level = sync_q[STAGES-1];

  // Reset values match the idle pin level so releasing reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      edge_q <= RST_VAL;
      rise   <= '0;
      fall   <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      edge_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~edge_q;
      fall   <= ~sync_q[STAGES-1] & edge_q;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap source arbiter and NMI / trap-mode controller for the Z80
// Purpose: tracks pending trap sources, enters/leaves trap mode on M1 falling edges,
//          records the winning cause and strobes the address-capture latch.
// Optional feature: define TRAP_CTRL_STATS_EN to add the saturating trap_count output.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   m1_n              Z80 M1 (asynchronous)
//   src_req/src_en    trap requests (asynchronous) and per-source enables
//   ack_valid/ack_idx clear one sticky pending bit
//   new_isr           current M1 fetch is a trap-vector entry
//   last_isr_jmp      current M1 fetch is the trap-exit jump
//   virtual_enabled   virtualisation active
//   trap_state        1 while in trap mode
//   nmi_n             registered active-low NMI
//   capture_address   address capture enable, one M1 cycle wide
//   pending           pending source vector
//   cause/cause_valid source that opened the current trap
//   trap_count        (TRAP_CTRL_STATS_EN only) saturating count of ISR entries
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int                 NUM_SRC     = 4,
  parameter logic [NUM_SRC-1:0] STICKY_MASK = 4'b1110,
  parameter int                 SYNC_STAGES = 2,
  localparam int                CAUSE_W     = cause_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m1_n,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               ack_valid,
  input  logic [CAUSE_W-1:0] ack_idx,
  input  logic               new_isr,
  input  logic               last_isr_jmp,
  input  logic               virtual_enabled,
  output logic               trap_state,
  output logic               nmi_n,
  output logic               capture_address,
  output logic [NUM_SRC-1:0] pending,
  output logic [CAUSE_W-1:0] cause,
  output logic               cause_valid
`ifdef TRAP_CTRL_STATS_EN
  ,
  output logic [7:0]         trap_count
`endif
);

  trap_state_e        state;
  logic               m1_s, m1_rise, m1_fall;
  logic [NUM_SRC-1:0] src_s, src_rise, src_fall;
  logic [NUM_SRC-1:0] pending_d;
  logic [CAUSE_W-1:0] winner;
  logic               pending_any;
  logic               isr_entry;
  logic               unused_ok;

  m1_edge_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_m1_sync (
    .clk(clk), .rst_n(rst_n), .din(m1_n),
    .level(m1_s), .rise(m1_rise), .fall(m1_fall)
  );

  m1_edge_sync #(.W(NUM_SRC), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_src_sync (
    .clk(clk), .rst_n(rst_n), .din(src_req),
    .level(src_s), .rise(src_rise), .fall(src_fall)
  );

  assign unused_ok   = &{1'b0, m1_s, src_fall};
  assign trap_state  = (state == TRAP);
  assign pending_any = |pending;
  assign isr_entry   = m1_fall && (state == RUN) && pending_any && new_isr;

  // Sticky bits latch on request edges only while running; a request edge during
  // a trap (or an ack) clears them, and clear beats set. Level bits resample at
  // the end of each M1 cycle.
  always_comb begin
    pending_d = pending;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (STICKY_MASK[i]) begin
        if ((ack_valid && ack_idx == CAUSE_W'(i)) || (src_rise[i] && trap_state))
          pending_d[i] = 1'b0;
        else if (src_rise[i] && src_en[i])
          pending_d[i] = 1'b1;
      end else if (m1_rise) begin
        pending_d[i] = src_s[i] & src_en[i];
      end
    end
  end

  // Lowest set index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) winner = CAUSE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= TRAP;
      nmi_n           <= 1'b1;
      capture_address <= 1'b0;
      pending         <= '0;
      cause           <= '0;
      cause_valid     <= 1'b0;
    end else begin
      pending <= pending_d;
      nmi_n   <= !(pending_any && state == RUN);
      if (m1_fall) begin
        capture_address <= 1'b0;
        unique case (state)
          RUN: begin
            if (isr_entry) begin
              state           <= TRAP;
              capture_address <= 1'b1;
              cause           <= winner;
              cause_valid     <= 1'b1;
            end else if (!virtual_enabled) begin
              state <= TRAP;
            end
          end
          TRAP: begin
            if (last_isr_jmp && virtual_enabled) begin
              state       <= RUN;
              cause_valid <= 1'b0;
            end
          end
          default: state <= TRAP;
        endcase
      end
    end
  end

`ifdef TRAP_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      trap_count <= 8'd0;
    else if (isr_entry && trap_count != 8'hFF)
      trap_count <= trap_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard testbench for trap_ctrl
module tb_trap_ctrl;

  localparam logic [3:0] STICKY = 4'b1110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m1_n = 1'b1;
  logic [3:0] src_req = 4'h0;
  logic [3:0] src_en = 4'hF;
  logic       ack_valid = 1'b0;
  logic [1:0] ack_idx = 2'd0;
  logic       new_isr = 1'b0;
  logic       last_isr_jmp = 1'b0;
  logic       virtual_enabled = 1'b1;
  logic       trap_state, nmi_n, capture_address, cause_valid;
  logic [3:0] pending;
  logic [1:0] cause;
  logic [7:0] count_act;

`ifdef TRAP_CTRL_STATS_EN
  logic [7:0] trap_count;
  assign count_act = trap_count;
`else
  assign count_act = 8'd0;
`endif

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .m1_n(m1_n), .src_req(src_req), .src_en(src_en),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .new_isr(new_isr),
    .last_isr_jmp(last_isr_jmp), .virtual_enabled(virtual_enabled),
    .trap_state(trap_state), .nmi_n(nmi_n), .capture_address(capture_address),
    .pending(pending), .cause(cause), .cause_valid(cause_valid)
`ifdef TRAP_CTRL_STATS_EN
    , .trap_count(trap_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ts;
    logic       nmi;
    logic       cap;
    logic [3:0] pend;
    logic [1:0] cause;
    logic       cv;
    logic [7:0] cnt;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  event  sample_ev;
  int    tests = 0;
  int    fails = 0;

  // Reference model state, updated per architectural event.
  bit       m_trap;
  bit [3:0] m_pend;
  bit [1:0] m_cause;
  bit       m_cv, m_cap;
  int       m_cnt;
  bit [3:0] m_req;
  bit [3:0] m_en;

  function automatic void model_reset();
    m_trap = 1; m_pend = 0; m_cause = 0; m_cv = 0; m_cap = 0; m_cnt = 0;
  endfunction

  function automatic bit [1:0] lowest(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic void apply_sticky(input bit [3:0] rises, input bit ackv, input int idx);
    for (int i = 0; i < 4; i++) begin
      if (STICKY[i]) begin
        if ((ackv && idx == i) || (rises[i] && m_trap)) m_pend[i] = 0;
        else if (rises[i] && m_en[i]) m_pend[i] = 1;
      end
    end
  endfunction

  // Monitor: pops one expectation per sample request and compares all outputs.
  initial begin
    snap_t act, e;
    string nm;
    forever begin
      @(sample_ev);
      @(negedge clk);
      act.ts = trap_state; act.nmi = nmi_n; act.cap = capture_address;
      act.pend = pending; act.cause = cause; act.cv = cause_valid; act.cnt = count_act;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got ts=%b nmi=%b cap=%b pend=%h cause=%0d cv=%b cnt=%0d ; expected ts=%b nmi=%b cap=%b pend=%h cause=%0d cv=%b cnt=%0d",
                 nm, act.ts, act.nmi, act.cap, act.pend, act.cause, act.cv, act.cnt,
                 e.ts, e.nmi, e.cap, e.pend, e.cause, e.cv, e.cnt);
      end
    end
  end

  task automatic check(input string nm);
    snap_t e;
    e.ts = m_trap; e.nmi = !((|m_pend) && !m_trap); e.cap = m_cap;
    e.pend = m_pend; e.cause = m_cause; e.cv = m_cv;
`ifdef TRAP_CTRL_STATS_EN
    e.cnt = 8'(m_cnt);
`else
    e.cnt = 8'd0;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    ->sample_ev;
    repeat (2) @(negedge clk);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic m1_cycle(input bit nisr, input bit lij, input bit ve);
    @(negedge clk);
    new_isr = nisr; last_isr_jmp = lij; virtual_enabled = ve; m1_n = 1'b0;
    m_cap = 0;
    if (!m_trap) begin
      if ((|m_pend) && nisr) begin
        m_trap = 1; m_cap = 1; m_cause = lowest(m_pend); m_cv = 1;
        if (m_cnt < 255) m_cnt++;
      end else if (!ve) begin
        m_trap = 1;
      end
    end else if (lij && ve) begin
      m_trap = 0; m_cv = 0;
    end
    settle();
    check("m1_fall");
    m1_n = 1'b1;
    for (int i = 0; i < 4; i++) if (!STICKY[i]) m_pend[i] = m_req[i] & m_en[i];
    settle();
    check("m1_rise");
    new_isr = 1'b0; last_isr_jmp = 1'b0;
  endtask

  task automatic set_req(input bit [3:0] v);
    @(negedge clk);
    apply_sticky(v & ~m_req, 0, 0);
    src_req = v; m_req = v;
    settle();
    check("src_req");
  endtask

  task automatic do_ack(input bit [1:0] idx);
    @(negedge clk);
    ack_valid = 1'b1; ack_idx = idx;
    @(negedge clk);
    ack_valid = 1'b0;
    apply_sticky(4'h0, 1, idx);
    settle();
    check("ack");
  endtask

  // Ack pulse lands on the same clock the synchronised request edge acts.
  task automatic ack_with_set(input bit [1:0] idx, input bit [3:0] v);
    @(negedge clk);
    apply_sticky(v & ~m_req, 1, idx);
    src_req = v; m_req = v;
    repeat (3) @(posedge clk);
    #1 ack_valid = 1'b1; ack_idx = idx;
    @(posedge clk);
    #1 ack_valid = 1'b0;
    settle();
    check("ack_set_same_clk");
  endtask

  task automatic set_en(input bit [3:0] v);
    @(negedge clk);
    src_en = v; m_en = v;
  endtask

  initial begin
    int r;
    model_reset();
    m_req = 0; m_en = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset");
    rst_n = 1'b1;
    settle();
    check("after_reset");

    // Exit, then IRQ entry.
    m1_cycle(0, 1, 1);
    set_req(4'b0001);
    m1_cycle(0, 0, 1);
    m1_cycle(1, 0, 1);
    set_req(4'b0000);
    m1_cycle(0, 1, 1);

    // Priority among sticky sources, ack in trap.
    set_req(4'b1010);
    m1_cycle(1, 0, 1);
    do_ack(2'd1);

    // Sticky edge during trap clears instead of setting.
    set_req(4'b1110);
    set_req(4'b1010);
    m1_cycle(0, 1, 1);
    do_ack(2'd3);
    set_req(4'b0000);

    // Ack and set on the same clock.
    ack_with_set(2'd2, 4'b0100);
    set_req(4'b0000);

    // Virtualisation off.
    m1_cycle(0, 0, 0);
    m1_cycle(0, 1, 0);
    set_req(4'b0010);
    m1_cycle(1, 0, 0);
    m1_cycle(0, 1, 1);

    // Randomised traffic.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      m1_cycle(1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0);
      else if (r <= 6) set_req(4'($urandom));
      else if (r == 7) do_ack(2'($urandom));
      else if (r == 8) set_en(4'($urandom));
      else             ack_with_set(2'($urandom), 4'($urandom));
    end

    // Repeated IRQ entry/exit; saturates the stats counter when present.
    set_en(4'hF);
    set_req(4'b0001);
    m1_cycle(0, 1, 1);
    for (int n = 0; n < 300; n++) begin
      m1_cycle(1, 0, 1);
      m1_cycle(0, 1, 1);
    end

    // Reset while in trap.
    set_req(4'b0000);
    m1_cycle(1, 0, 1);
    m1_cycle(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    check("reset_mid_trap");
    rst_n = 1'b1;
    settle();
    check("after_mid_reset");

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d outstanding expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
